quick_spi_slave: RTL and testbench
==================================

QUICK_SPI_SLAVE -- requirements
Module: quick_spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SPI frame (range 2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on sclk/ss_n/mosi (range 2..3).
REQ-003 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpol  input  1  SPI clock idle level.
REQ-006 SHALL have port cpha  input  1  SPI clock phase.
REQ-007 SHALL have port sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-008 SHALL have port ss_n  input  1  slave select from master, active-low.
REQ-009 SHALL have port mosi  input  1  serial data from master.
REQ-010 SHALL have port miso  output  1  serial data to master; high-Z while not selected.
REQ-011 SHALL have port tx_data  input  DATA_WIDTH  next word to transmit.
REQ-012 SHALL have port tx_valid  input  1  tx_data valid.
REQ-013 SHALL have port tx_ready  output  1  tx holding register empty.
REQ-014 SHALL have port rx_data  output  DATA_WIDTH  last completely received word.
REQ-015 SHALL have port rx_valid  output  1  one-clk pulse; rx_data updated.
REQ-016 SHALL have port busy  output  1  ss_n (synchronised) asserted.

Function
REQ-017 SHALL pass sclk, ss_n and mosi through SYNC_STAGES flip-flops, then detect edges using one further register stage.
REQ-018 SHALL capture cpol/cpha on the synchronised ss_n falling edge; the values SHALL hold for the whole selection.
REQ-019 SHALL use a state machine with states IDLE, LOAD and SHIFT: IDLE->LOAD on ss_n fall; LOAD->SHIFT after 1 clk; SHIFT->LOAD at each frame boundary; any state->IDLE on ss_n rise.
REQ-020 SHALL transfer bits LSB first; bit counter width SHALL be $clog2(DATA_WIDTH).
REQ-021 SHALL, in LOAD, copy the holding register to the shift register and set tx_ready=1; if the holding register is empty, all-zero SHALL be shifted (underrun).
REQ-022 SHALL drive the bit 0 value on miso in LOAD when cpha=0; when cpha=1, bit 0 SHALL be driven on the first leading sclk edge.
REQ-023 SHALL sample mosi on the leading edge (cpha=0) or the trailing edge (cpha=1), where leading means sclk leaving the cpol level.
REQ-024 SHALL shift the next miso bit out on the opposite edge to the sampling edge.
REQ-025 SHALL, on the DATA_WIDTH-th sample, write rx_data and pulse rx_valid 1 clk later, then return to LOAD; back-to-back frames SHALL continue while ss_n stays low.
REQ-026 SHALL accept a tx word when tx_valid && tx_ready; tx_ready SHALL drop the following cycle.
REQ-027 SHALL not lose a tx write that coincides with LOAD; the write SHALL have priority and be sent in that frame.
REQ-028 SHALL, on ss_n rise mid-frame, discard the partial word with no rx_valid, clear the bit counter, and tri-state miso within SYNC_STAGES+2 clk.
REQ-029 SHALL meet REQ-023/024 only when every sclk high and low phase lasts at least SYNC_STAGES+2 clk periods.

Reset
REQ-030 SHALL reset asynchronously to: state IDLE, miso=Z, tx_ready=1, rx_data=0, rx_valid=0, busy=0, counters 0, holding register empty.
REQ-031 SHALL, when reset is asserted mid-frame, abandon the frame immediately; a frame SHALL start only on an ss_n fall seen after reset release.

Configuration
REQ-032 SHALL, with QUICK_SPI_SLAVE_STATUS_EN defined, add outputs overrun (rx_valid while previous word unread, requiring input rx_ack), underrun (REQ-021 zero-fill) and frame_abort (REQ-028); each SHALL be sticky until reset or clear_status pulse.
REQ-033 SHALL, without QUICK_SPI_SLAVE_STATUS_EN, omit those ports and their logic; all other behaviour SHALL be identical.

Structure
REQ-034 SHALL place the state encoding (SS_IDLE, SS_LOAD, SS_SHIFT) and the edge-select constants in shared package quick_spi_pkg, alongside master state constants.
REQ-035 SHALL implement the synchroniser as sub-module quick_spi_sync (parameterised depth, one bit), instantiated three times.

Verification
REQ-036 SHALL verify: mode 0, DATA_WIDTH=8, tx 0xA5, master sends 0x3C -> rx_data=0x3C with one rx_valid; master receives 0xA5 LSB first.
REQ-037 SHALL verify: modes 1, 2 and 3 each with master 0x81 and slave 0x7E -> both sides receive the correct word.
REQ-038 SHALL verify: 3 back-to-back frames under one ss_n with tx 0x11/0x22/0x33 loaded on each tx_ready -> master receives 0x11, 0x22, 0x33; three rx_valid pulses.
REQ-039 SHALL verify: no tx write before frame -> master receives 0x00; with QUICK_SPI_SLAVE_STATUS_EN, underrun=1.
REQ-040 SHALL verify: ss_n raised after 5 bits -> no rx_valid, miso=Z, next full frame received correctly.
REQ-041 SHALL verify: reset_n pulsed mid-frame -> all outputs at reset values asynchronously; next frame after release is correct.

Source files
------------

// File: rtl/quick_spi_pkg.sv
// rtl/quick_spi_pkg.sv - shared SPI state encodings and edge-select constants
package quick_spi_pkg;

    typedef enum logic [1:0] {
        SS_IDLE  = 2'd0,
        SS_LOAD  = 2'd1,
        SS_SHIFT = 2'd2
    } slave_state_t;

    typedef enum logic [1:0] {
        MS_IDLE     = 2'd0,
        MS_SELECT   = 2'd1,
        MS_XFER     = 2'd2,
        MS_DESELECT = 2'd3
    } master_state_t;

    localparam logic EDGE_LEAD  = 1'b0;
    localparam logic EDGE_TRAIL = 1'b1;

    // cpha=0 samples on the leading sclk edge, cpha=1 on the trailing one
    function automatic logic sample_edge_sel(input logic cpha);
        return cpha ? EDGE_TRAIL : EDGE_LEAD;
    endfunction

endpackage

// File: rtl/quick_spi_sync.sv
// rtl/quick_spi_sync.sv - single-bit multi-stage synchroniser
module quick_spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/quick_spi_slave.sv
// rtl/quick_spi_slave.sv - SPI slave, all SPI modes, LSB first; status flags with QUICK_SPI_SLAVE_STATUS_EN
module quick_spi_slave
    import quick_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
`ifdef QUICK_SPI_SLAVE_STATUS_EN
    ,
    input  logic                  rx_ack,
    input  logic                  clear_status,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  frame_abort
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_s, ss_s, mosi_s;
    logic sclk_d, ss_d, ss_armed;

    quick_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d(sclk), .q(sclk_s)
    );

    // ss_n chain resets low so a select held through reset never looks like a new fall
    quick_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .d(ss_n), .q(ss_s)
    );

    quick_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s)
    );

    slave_state_t          state, state_nxt;
    logic                  cpol_q, cpha_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  miso_q;

    logic ss_sel, ss_fall;
    logic sclk_rise, sclk_fall, lead_evt, trail_evt;
    logic sample_evt, shift_evt, frame_done, tx_accept;
    logic [DATA_WIDTH-1:0] load_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_d   <= 1'b0;
            ss_d     <= 1'b0;
            ss_armed <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
            if (ss_s) begin
                ss_armed <= 1'b1;
            end
        end
    end

    assign ss_sel    = ss_armed & ~ss_s;
    assign ss_fall   = ss_armed & ss_d & ~ss_s;
    assign busy      = ss_sel;

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign lead_evt  = cpol_q ? sclk_fall : sclk_rise;
    assign trail_evt = cpol_q ? sclk_rise : sclk_fall;

    assign sample_evt = (sample_edge_sel(cpha_q) == EDGE_TRAIL) ? trail_evt : lead_evt;
    assign shift_evt  = (sample_edge_sel(cpha_q) == EDGE_TRAIL) ? lead_evt : trail_evt;

    assign frame_done = (state == SS_SHIFT) && ss_sel && sample_evt && (bit_cnt == LAST_BIT);
    assign tx_accept  = tx_valid && tx_ready;

    // A write landing in the LOAD cycle bypasses the holding register
    assign load_word  = tx_accept ? tx_data : (tx_ready ? '0 : hold);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SS_IDLE:  if (ss_fall) state_nxt = SS_LOAD;
            SS_LOAD:  state_nxt = SS_SHIFT;
            SS_SHIFT: if (frame_done) state_nxt = SS_LOAD;
            default:  state_nxt = SS_IDLE;
        endcase
        if (!ss_sel) begin
            state_nxt = SS_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            bit_cnt  <= '0;
            hold     <= '0;
            tx_ready <= 1'b1;
            tx_sr    <= '0;
            rx_sr    <= '0;
            miso_q   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (ss_fall) begin
                cpol_q <= cpol;
                cpha_q <= cpha;
            end

            if (tx_accept) begin
                hold <= tx_data;
            end
            if (state == SS_LOAD) begin
                tx_ready <= 1'b1;
            end else if (tx_accept) begin
                tx_ready <= 1'b0;
            end

            case (state)
                SS_LOAD: begin
                    bit_cnt <= '0;
                    if (!cpha_q) begin
                        miso_q <= load_word[0];
                        tx_sr  <= load_word >> 1;
                    end else begin
                        tx_sr  <= load_word;
                    end
                end
                SS_SHIFT: begin
                    if (!ss_sel) begin
                        bit_cnt <= '0;
                    end else begin
                        // cpha=0: the trailing edge closing the previous frame arrives with bit_cnt=0 and is ignored
                        if (shift_evt && (cpha_q || (bit_cnt != '0))) begin
                            miso_q <= tx_sr[0];
                            tx_sr  <= tx_sr >> 1;
                        end
                        if (sample_evt) begin
                            rx_sr <= {mosi_s, rx_sr[DATA_WIDTH-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt  <= '0;
                                rx_data  <= {mosi_s, rx_sr[DATA_WIDTH-1:1]};
                                rx_valid <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign miso = (state != SS_IDLE) ? miso_q : 1'bz;

`ifdef QUICK_SPI_SLAVE_STATUS_EN
    logic rx_unread;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_unread   <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            if (rx_valid) begin
                rx_unread <= 1'b1;
            end else if (rx_ack) begin
                rx_unread <= 1'b0;
            end
            if (clear_status) begin
                overrun     <= 1'b0;
                underrun    <= 1'b0;
                frame_abort <= 1'b0;
            end else begin
                if (rx_valid && rx_unread && !rx_ack) begin
                    overrun <= 1'b1;
                end
                if ((state == SS_LOAD) && tx_ready && !tx_accept) begin
                    underrun <= 1'b1;
                end
                if ((state == SS_SHIFT) && !ss_sel && (bit_cnt != '0)) begin
                    frame_abort <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_quick_spi_slave.sv
// tb/tb_quick_spi_slave.sv - directed bench with scoreboard for quick_spi_slave
module tb_quick_spi_slave;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          cpol     = 1'b0;
    logic          cpha     = 1'b0;
    logic          sclk     = 1'b0;
    logic          ss_n     = 1'b1;
    logic          mosi     = 1'b0;
    wire           miso;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
`ifdef QUICK_SPI_SLAVE_STATUS_EN
    logic          rx_ack       = 1'b0;
    logic          clear_status = 1'b0;
    logic          overrun, underrun, frame_abort;
`endif

    // undriven miso reads 1, so high-Z is visible as a 1 while the slave would drive 0
    pullup (miso);

    always #5 clk = ~clk;

    quick_spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef QUICK_SPI_SLAVE_STATUS_EN
        , .rx_ack(rx_ack), .clear_status(clear_status),
        .overrun(overrun), .underrun(underrun), .frame_abort(frame_abort)
`endif
    );

    int total = 0;
    int bad   = 0;
    int rx_pulses = 0;

    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] exp_rx_q[$];
    logic [DW-1:0] m_words[3];
    logic [DW-1:0] s_rx[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // SPI master: clocks nbits from m_words LSB first, collects miso into s_rx
    task automatic spi_session(input logic [1:0] mode, input int nbits);
        int w, b;
        for (int k = 0; k < nbits / DW; k++) exp_rx_q.push_back(m_words[k]);
        cpol = mode[1];
        cpha = mode[0];
        sclk = mode[1];
        mosi = m_words[0][0];
        wait_clk(4);
        ss_n = 1'b0;
        wait_clk(10);
        for (int i = 0; i < nbits; i++) begin
            w = i / DW;
            b = i % DW;
            if (!cpha) begin
                mosi = m_words[w][b];
                wait_clk(HALF);
                sclk = ~cpol;
                s_rx[w][b] = miso;
                wait_clk(HALF);
                sclk = cpol;
            end else begin
                wait_clk(HALF);
                sclk = ~cpol;
                mosi = m_words[w][b];
                wait_clk(HALF);
                sclk = cpol;
                s_rx[w][b] = miso;
            end
        end
        wait_clk(HALF);
    endtask

    task automatic spi_deselect();
        ss_n = 1'b1;
        wait_clk(HALF);
    endtask

    // tx feeder: writes the next queued word whenever the holding register is empty
    initial begin
        forever begin
            @(negedge clk);
            if (tx_ready && (tx_q.size() > 0)) begin
                tx_data  = tx_q.pop_front();
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
        end
    end

    // per-cycle compare against the model: rx scoreboard, busy follows ss_n, miso released when deselected
    initial begin
        int   ss_stable;
        logic ss_prev;
        logic rv_prev;
        ss_stable = 0;
        ss_prev   = 1'b1;
        rv_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n || (ss_n !== ss_prev)) ss_stable = 0;
            else if (ss_stable < 1000) ss_stable++;
            ss_prev = ss_n;
            if (reset_n) begin
                if (rx_valid) begin
                    rx_pulses++;
                    check("rx_valid_width", {31'b0, rv_prev}, 32'd0);
                    if (exp_rx_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_unexpected: rx_valid with rx_data %0h, no word expected", rx_data);
                    end else begin
                        check("rx_data", rx_data, exp_rx_q.pop_front());
                    end
                end
                if (ss_stable >= SYNC + 3) begin
                    check("busy", busy, !ss_n);
                    if (ss_n) check("miso_idle_z", miso, 32'd1);
                end
            end
            rv_prev = rx_valid;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int p0;

        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(8);
        check("rst_tx_ready", tx_ready, 32'd1);
        check("rst_rx_data",  rx_data,  32'd0);
        check("rst_rx_valid", rx_valid, 32'd0);
        check("rst_busy",     busy,     32'd0);
        check("rst_miso_z",   miso,     32'd1);

        // mode 0: slave 0xA5, master 0x3C
        tx_q.push_back(8'hA5);
        m_words[0] = 8'h3C;
        p0 = rx_pulses;
        spi_session(2'd0, 8);
        check("m0_busy_sel", busy, 32'd1);
        spi_deselect();
        check("m0_master_rx", s_rx[0], 32'hA5);
        check("m0_rx_data", rx_data, 32'h3C);
        check("m0_rx_pulses", rx_pulses - p0, 32'd1);

        // modes 1..3: master 0x81, slave 0x7E
        for (int m = 1; m < 4; m++) begin
            tx_q.push_back(8'h7E);
            m_words[0] = 8'h81;
            p0 = rx_pulses;
            spi_session(m[1:0], 8);
            spi_deselect();
            check($sformatf("mode%0d_master_rx", m), s_rx[0], 32'h7E);
            check($sformatf("mode%0d_rx_data", m), rx_data, 32'h81);
            check($sformatf("mode%0d_rx_pulses", m), rx_pulses - p0, 32'd1);
        end

        // three back-to-back frames under one select, modes 0 and 3
        for (int m = 0; m < 4; m += 3) begin
            tx_q.push_back(8'h11);
            tx_q.push_back(8'h22);
            tx_q.push_back(8'h33);
            m_words[0] = 8'hC1;
            m_words[1] = 8'hD2;
            m_words[2] = 8'hE3;
            p0 = rx_pulses;
            spi_session(m[1:0], 24);
            spi_deselect();
            check("b2b_master_rx0", s_rx[0], 32'h11);
            check("b2b_master_rx1", s_rx[1], 32'h22);
            check("b2b_master_rx2", s_rx[2], 32'h33);
            check("b2b_rx_pulses", rx_pulses - p0, 32'd3);
            check("b2b_tx_ready", tx_ready, 32'd1);
        end

        // underrun: nothing written, slave shifts zeros
        m_words[0] = 8'h5A;
        spi_session(2'd0, 8);
        spi_deselect();
        check("underrun_master_rx", s_rx[0], 32'h00);
        check("underrun_rx_data", rx_data, 32'h5A);
`ifdef QUICK_SPI_SLAVE_STATUS_EN
        check("underrun_flag", underrun, 32'd1);
`endif

        // abort after 5 bits, then a clean frame
        m_words[0] = 8'hFF;
        p0 = rx_pulses;
        spi_session(2'd0, 5);
        ss_n = 1'b1;
        wait_clk(SYNC + 2);
        check("abort_miso_z", miso, 32'd1);
        wait_clk(HALF);
        check("abort_no_rx", rx_pulses - p0, 32'd0);
        check("abort_rx_data_kept", rx_data, 32'h5A);
`ifdef QUICK_SPI_SLAVE_STATUS_EN
        check("abort_flag", frame_abort, 32'd1);
`endif
        tx_q.push_back(8'hC3);
        m_words[0] = 8'h96;
        p0 = rx_pulses;
        spi_session(2'd0, 8);
        spi_deselect();
        check("post_abort_master_rx", s_rx[0], 32'hC3);
        check("post_abort_rx_data", rx_data, 32'h96);
        check("post_abort_rx_pulses", rx_pulses - p0, 32'd1);

        // reset pulsed mid-frame with the holding register full
        tx_q.push_back(8'hF0);
        tx_q.push_back(8'h44);
        m_words[0] = 8'h0F;
        spi_session(2'd0, 3);
        check("pre_rst_tx_ready", tx_ready, 32'd0);
        #3;
        reset_n = 1'b0;
        ss_n    = 1'b1;
        #1;
        check("async_rst_tx_ready", tx_ready, 32'd1);
        check("async_rst_rx_data",  rx_data,  32'd0);
        check("async_rst_rx_valid", rx_valid, 32'd0);
        check("async_rst_busy",     busy,     32'd0);
        check("async_rst_miso_z",   miso,     32'd1);
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(6);
        tx_q.push_back(8'h69);
        m_words[0] = 8'hB4;
        p0 = rx_pulses;
        spi_session(2'd1, 8);
        spi_deselect();
        check("post_rst_master_rx", s_rx[0], 32'h69);
        check("post_rst_rx_data", rx_data, 32'hB4);
        check("post_rst_rx_pulses", rx_pulses - p0, 32'd1);
        check("scoreboard_empty", exp_rx_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
